// File: rtl/ccip_rd_requester.sv
// CCI-P channel 0 read initiator: streams num_lines cache-line reads from base_addr and forwards responses.
// Optional running checksum of returned data[63:0] when CCIP_RD_CHECKSUM_EN is defined.
module ccip_rd_requester #(
  parameter int MAX_OUTSTANDING = 16,
  parameter int LEN_W           = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [41:0]      base_addr,
  input  logic [LEN_W-1:0] num_lines,
  input  logic             c0_almost_full,
  output logic             c0_req_valid,
  output logic [41:0]      c0_req_addr,
  output logic [LEN_W-1:0] c0_req_mdata,
  input  logic             c0_rsp_valid,
  input  logic [LEN_W-1:0] c0_rsp_mdata,
  input  logic [511:0]     c0_rsp_data,
  output logic             out_valid,
  output logic [LEN_W-1:0] out_idx,
  output logic [511:0]     out_data,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [63:0]      checksum
);

  localparam int OW = $clog2(MAX_OUTSTANDING) + 1;
  localparam logic [OW-1:0]    O_ONE = 1;
  localparam logic [OW-1:0]    O_MAX = MAX_OUTSTANDING;
  localparam logic [LEN_W-1:0] L_ONE = 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t           state;
  logic [41:0]      base_q;
  logic [LEN_W-1:0] num_q;
  logic [LEN_W-1:0] issue_idx;
  logic [LEN_W-1:0] rsp_cnt;
  logic [OW-1:0]    outstanding;
  logic             issue_ok;
  logic             rsp_acc;
  logic             rsp_bad;

  always_comb begin
    issue_ok = (state == ISSUE) && !c0_almost_full && (outstanding < O_MAX) && (issue_idx < num_q);
    rsp_acc  = c0_rsp_valid && ((state == ISSUE) || (state == DRAIN)) && (c0_rsp_mdata < num_q);
    rsp_bad  = c0_rsp_valid && !rsp_acc;
  end

`ifdef CCIP_RD_CHECKSUM_EN
  logic [63:0] csum;
  assign checksum = csum;
`else
  assign checksum = 64'd0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      base_q       <= '0;
      num_q        <= '0;
      issue_idx    <= '0;
      rsp_cnt      <= '0;
      outstanding  <= '0;
      c0_req_valid <= 1'b0;
      c0_req_addr  <= '0;
      c0_req_mdata <= '0;
      out_valid    <= 1'b0;
      out_idx      <= '0;
      out_data     <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
`ifdef CCIP_RD_CHECKSUM_EN
      csum         <= '0;
`endif
    end else begin
      c0_req_valid <= 1'b0;
      out_valid    <= rsp_acc;
      // done trails the DONE state by one register stage
      done         <= (state == DONE);

      if (rsp_acc) begin
        out_idx  <= c0_rsp_mdata;
        out_data <= c0_rsp_data;
        rsp_cnt  <= rsp_cnt + L_ONE;
`ifdef CCIP_RD_CHECKSUM_EN
        csum     <= csum + c0_rsp_data[63:0];
`endif
      end
      if (rsp_bad) err <= 1'b1;

      if (issue_ok && !rsp_acc)      outstanding <= outstanding + O_ONE;
      else if (!issue_ok && rsp_acc) outstanding <= outstanding - O_ONE;

      case (state)
        IDLE: begin
          if (start) begin
            base_q    <= base_addr;
            num_q     <= num_lines;
            issue_idx <= '0;
            rsp_cnt   <= '0;
            err       <= 1'b0;
`ifdef CCIP_RD_CHECKSUM_EN
            csum      <= '0;
`endif
            if (num_lines == '0) begin
              state <= DONE;
            end else begin
              state <= ISSUE;
              busy  <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (issue_ok) begin
            c0_req_valid <= 1'b1;
            c0_req_addr  <= base_q + {{(42-LEN_W){1'b0}}, issue_idx};
            c0_req_mdata <= issue_idx;
            issue_idx    <= issue_idx + L_ONE;
            if (issue_idx == num_q - L_ONE) state <= DRAIN;
          end
        end
        DRAIN: begin
          if ((outstanding == '0) && (rsp_cnt == num_q)) begin
            state <= DONE;
            busy  <= 1'b0;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ccip_rd_requester.sv
// Directed bench for ccip_rd_requester, built with MAX_OUTSTANDING=4.
module tb_ccip_rd_requester;

  localparam int LEN_W = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [41:0]      base_addr;
  logic [LEN_W-1:0] num_lines;
  logic             c0_almost_full;
  logic             c0_req_valid;
  logic [41:0]      c0_req_addr;
  logic [LEN_W-1:0] c0_req_mdata;
  logic             c0_rsp_valid;
  logic [LEN_W-1:0] c0_rsp_mdata;
  logic [511:0]     c0_rsp_data;
  logic             out_valid;
  logic [LEN_W-1:0] out_idx;
  logic [511:0]     out_data;
  logic             busy;
  logic             done;
  logic             err;
  logic [63:0]      checksum;

  int n_cmp = 0;
  int n_bad = 0;

  ccip_rd_requester #(.MAX_OUTSTANDING(4), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .num_lines(num_lines),
    .c0_almost_full(c0_almost_full), .c0_req_valid(c0_req_valid), .c0_req_addr(c0_req_addr),
    .c0_req_mdata(c0_req_mdata), .c0_rsp_valid(c0_rsp_valid), .c0_rsp_mdata(c0_rsp_mdata),
    .c0_rsp_data(c0_rsp_data), .out_valid(out_valid), .out_idx(out_idx), .out_data(out_data),
    .busy(busy), .done(done), .err(err), .checksum(checksum)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    start = 0; c0_rsp_valid = 0; c0_almost_full = 0;
    rst_n = 0;
    #2;
    rst_n = 1;
    cyc();
  endtask

  task automatic kick(input logic [41:0] b, input logic [LEN_W-1:0] n);
    base_addr = b; num_lines = n; start = 1;
    cyc();
    start = 0;
  endtask

  task automatic test_reset();
    n_cmp++; if ({c0_req_valid, out_valid, busy, done, err} !== 5'b0) begin n_bad++;
      $display("FAIL reset_flags got %b want 00000", {c0_req_valid, out_valid, busy, done, err}); end
    n_cmp++; if (checksum !== 64'd0 || out_idx !== '0 || c0_req_addr !== 42'd0) begin n_bad++;
      $display("FAIL reset_data checksum=%0h out_idx=%0d addr=%0h want 0", checksum, out_idx, c0_req_addr); end
  endtask

  task automatic test_basic();
    int dn = 0;
    kick(42'h100, 4);
    n_cmp++; if (busy !== 1'b1 || c0_req_valid !== 1'b0) begin n_bad++;
      $display("FAIL basic_first busy=%b req=%b want 1 0", busy, c0_req_valid); end
    for (int i = 0; i < 4; i++) begin
      cyc();
      n_cmp++; if (c0_req_valid !== 1'b1 || c0_req_addr !== 42'h100 + 42'(i) || c0_req_mdata !== LEN_W'(i)) begin
        n_bad++; $display("FAIL basic_req%0d got v=%b a=%0h m=%0d want 1 %0h %0d", i, c0_req_valid, c0_req_addr, c0_req_mdata, 42'h100 + 42'(i), i); end
    end
    cyc();
    n_cmp++; if (c0_req_valid !== 1'b0) begin n_bad++; $display("FAIL basic_req_end got %b want 0", c0_req_valid); end
    for (int i = 0; i < 4; i++) begin
      c0_rsp_valid = 1; c0_rsp_mdata = LEN_W'(i); c0_rsp_data = 512'(i + 1);
      cyc();
      n_cmp++; if (out_valid !== 1'b1 || out_idx !== LEN_W'(i) || out_data !== 512'(i + 1)) begin
        n_bad++; $display("FAIL basic_out%0d got v=%b idx=%0d d=%0h", i, out_valid, out_idx, out_data[63:0]); end
    end
    c0_rsp_valid = 0;
    for (int i = 0; i < 10; i++) begin cyc(); if (done) dn++; end
    n_cmp++; if (dn !== 1) begin n_bad++; $display("FAIL basic_done_count got %0d want 1", dn); end
    n_cmp++; if (err !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL basic_end err=%b busy=%b want 0 0", err, busy); end
  endtask

  task automatic test_zero();
    kick(42'h40, 0);
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0 || c0_req_valid !== 1'b0) begin n_bad++;
      $display("FAIL zero_c1 busy=%b done=%b req=%b want 000", busy, done, c0_req_valid); end
    cyc();
    n_cmp++; if (done !== 1'b1 || busy !== 1'b0 || c0_req_valid !== 1'b0) begin n_bad++;
      $display("FAIL zero_c2 done=%b busy=%b req=%b want 1 0 0", done, busy, c0_req_valid); end
    cyc();
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL zero_c3 done=%b want 0", done); end
  endtask

  task automatic test_outstanding();
    int nreq = 0;
    logic [LEN_W-1:0] last_m = '0;
    kick(42'h0, 10);
    for (int i = 0; i < 12; i++) begin cyc(); if (c0_req_valid) nreq++; end
    n_cmp++; if (nreq !== 4) begin n_bad++; $display("FAIL limit_stall got %0d reqs want 4", nreq); end
    c0_rsp_valid = 1; c0_rsp_mdata = 0; c0_rsp_data = 512'h5;
    cyc();
    c0_rsp_valid = 0;
    n_cmp++; if (out_valid !== 1'b1 || out_idx !== '0) begin n_bad++;
      $display("FAIL limit_rsp v=%b idx=%0d want 1 0", out_valid, out_idx); end
    nreq = 0;
    for (int i = 0; i < 8; i++) begin cyc(); if (c0_req_valid) begin nreq++; last_m = c0_req_mdata; end end
    n_cmp++; if (nreq !== 1 || last_m !== LEN_W'(4)) begin n_bad++;
      $display("FAIL limit_resume got %0d reqs mdata=%0d want 1 4", nreq, last_m); end
    do_reset();
  endtask

  task automatic test_almost_full();
    kick(42'h200, 4);
    cyc();
    n_cmp++; if (c0_req_valid !== 1'b1 || c0_req_mdata !== '0) begin n_bad++;
      $display("FAIL af_req0 v=%b m=%0d want 1 0", c0_req_valid, c0_req_mdata); end
    c0_almost_full = 1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      n_cmp++; if (c0_req_valid !== 1'b0) begin n_bad++; $display("FAIL af_hold%0d v=%b want 0", i, c0_req_valid); end
    end
    c0_almost_full = 0;
    for (int i = 1; i < 4; i++) begin
      cyc();
      n_cmp++; if (c0_req_valid !== 1'b1 || c0_req_addr !== 42'h200 + 42'(i) || c0_req_mdata !== LEN_W'(i)) begin
        n_bad++; $display("FAIL af_resume%0d v=%b a=%0h m=%0d", i, c0_req_valid, c0_req_addr, c0_req_mdata); end
    end
    do_reset();
    kick(42'h3FF_FFFF_FFFF, 2);
    cyc();
    n_cmp++; if (c0_req_valid !== 1'b1 || c0_req_addr !== 42'h3FF_FFFF_FFFF) begin n_bad++;
      $display("FAIL wrap_first v=%b a=%0h want 1 3ffffffffff", c0_req_valid, c0_req_addr); end
    cyc();
    n_cmp++; if (c0_req_valid !== 1'b1 || c0_req_addr !== 42'h0 || c0_req_mdata !== LEN_W'(1)) begin n_bad++;
      $display("FAIL wrap_second v=%b a=%0h m=%0d want 1 0 1", c0_req_valid, c0_req_addr, c0_req_mdata); end
    do_reset();
  endtask

  task automatic test_out_of_order();
    logic [LEN_W-1:0] ord [4] = '{2, 0, 3, 1};
    logic [63:0] exp_sum;
    int dn = 0;
`ifdef CCIP_RD_CHECKSUM_EN
    exp_sum = 64'd10;
`else
    exp_sum = 64'd0;
`endif
    kick(42'h0, 4);
    for (int i = 0; i < 5; i++) cyc();
    for (int i = 0; i < 4; i++) begin
      c0_rsp_valid = 1; c0_rsp_mdata = ord[i]; c0_rsp_data = 512'(ord[i] + 1);
      cyc();
      n_cmp++; if (out_valid !== 1'b1 || out_idx !== ord[i] || out_data[63:0] !== 64'(ord[i] + 1)) begin
        n_bad++; $display("FAIL ooo_out%0d v=%b idx=%0d want 1 %0d", i, out_valid, out_idx, ord[i]); end
    end
    c0_rsp_valid = 0;
    cyc();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL ooo_quiet v=%b want 0", out_valid); end
    n_cmp++; if (checksum !== exp_sum) begin n_bad++; $display("FAIL ooo_checksum got %0d want %0d", checksum, exp_sum); end
    for (int i = 0; i < 10; i++) begin cyc(); if (done) dn++; end
    n_cmp++; if (dn !== 1 || err !== 1'b0 || checksum !== exp_sum) begin n_bad++;
      $display("FAIL ooo_done dn=%0d err=%b sum=%0d want 1 0 %0d", dn, err, checksum, exp_sum); end
  endtask

  task automatic test_err_reset();
    kick(42'h0, 4);
    for (int i = 0; i < 5; i++) cyc();
    c0_rsp_valid = 1; c0_rsp_mdata = 7; c0_rsp_data = 512'h99;
    cyc();
    n_cmp++; if (out_valid !== 1'b0 || err !== 1'b1) begin n_bad++;
      $display("FAIL stray v=%b err=%b want 0 1", out_valid, err); end
    c0_rsp_mdata = 0; c0_rsp_data = 512'h1;
    cyc();
    c0_rsp_valid = 0;
    n_cmp++; if (out_valid !== 1'b1 || out_idx !== '0 || busy !== 1'b1) begin n_bad++;
      $display("FAIL stray_next v=%b idx=%0d busy=%b want 1 0 1", out_valid, out_idx, busy); end
    rst_n = 0;
    #1;
    n_cmp++; if ({c0_req_valid, out_valid, busy, done, err} !== 5'b0 || checksum !== 64'd0 || out_data !== '0) begin
      n_bad++; $display("FAIL midreset flags=%b sum=%0h want 00000 0", {c0_req_valid, out_valid, busy, done, err}, checksum); end
    rst_n = 1;
    cyc();
    c0_rsp_valid = 1; c0_rsp_mdata = 1; c0_rsp_data = 512'h2;
    cyc();
    c0_rsp_valid = 0;
    n_cmp++; if (err !== 1'b1 || out_valid !== 1'b0) begin n_bad++;
      $display("FAIL late_rsp err=%b v=%b want 1 0", err, out_valid); end
    kick(42'h0, 0);
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL start_clears_err err=%b want 0", err); end
    cyc();
    cyc();
  endtask

  initial begin
    rst_n = 0; start = 0; base_addr = '0; num_lines = '0; c0_almost_full = 0;
    c0_rsp_valid = 0; c0_rsp_mdata = '0; c0_rsp_data = '0;
    #12;
    test_reset();
    rst_n = 1;
    cyc();
    test_basic();
    test_zero();
    test_outstanding();
    test_almost_full();
    test_out_of_order();
    test_err_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
